// File: rtl/victory_tracker.sv
// Purpose : round/match referee for a two-player light-chase game; keeps both scores, shows them on 7-seg digits.
// Latency : a win sampled on edge N is visible on score_*/game_over after edge N; hex_* follow the scores combinationally.
// Backpressure: none; L/R are one-cycle pulses, and presses during ROUND_END or MATCH_OVER are simply discarded.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; overrides everything
//   L, R       conditioned one-cycle press pulses from the left / right player
//   left_end   leftmost playfield light is lit
//   right_end  rightmost playfield light is lit
//   game_over  high while a round is finished (ROUND_END) or the match is over
//   match_over high once a player has reached 7 points, until reset
//   score_l/r  3-bit scores, 0..7
//   hex_l/r    active-low 7-segment codes {g,f,e,d,c,b,a} for the scores

module victory_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       left_end,
    input  logic       right_end,
    output logic       game_over,
    output logic       match_over,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r
);

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        ROUND_END  = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    // Score at which the match ends; a score only ever reaches this value
    // on the same edge that moves the FSM into MATCH_OVER.
    localparam logic [2:0] WIN_SCORE = 3'd7;

    state_t     state_q, state_d;
    logic [2:0] score_l_q, score_l_d;
    logic [2:0] score_r_q, score_r_d;
    logic       left_win, right_win;

    // Active-low segment decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [2:0] val);
        logic [6:0] seg;
        case (val)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
        return seg;
    endfunction

    // A win needs the player's own end lit, their own press, and neither the
    // opponent's press nor the opposite end lit. Both presses together, or
    // both ends lit together, therefore produce no win at all.
    assign left_win  = left_end  & L & ~R & ~right_end;
    assign right_win = right_end & R & ~L & ~left_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PLAY;
            score_l_q <= 3'd0;
            score_r_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        case (state_q)
            PLAY: begin
                // In PLAY a score is at most WIN_SCORE-1, so the increment
                // cannot wrap.
                if (left_win) begin
                    score_l_d = score_l_q + 3'd1;
                    state_d   = (score_l_d == WIN_SCORE) ? MATCH_OVER : ROUND_END;
                end else if (right_win) begin
                    score_r_d = score_r_q + 3'd1;
                    state_d   = (score_r_d == WIN_SCORE) ? MATCH_OVER : ROUND_END;
                end
            end
            // One-cycle pause that lets the playfield re-centre; presses ignored.
            ROUND_END:  state_d = PLAY;
            // Absorbing until reset; scores frozen.
            MATCH_OVER: state_d = MATCH_OVER;
            default:    state_d = PLAY;
        endcase
    end

    // Decoded straight from the state register, so both are glitch-free and
    // game_over rises on the edge that registers the win.
    assign game_over  = (state_q != PLAY);
    assign match_over = (state_q == MATCH_OVER);

    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign hex_l   = seg7(score_l_q);
    assign hex_r   = seg7(score_r_q);

endmodule

// File: tb/tb_victory_tracker.sv
// Purpose : self-checking bench for victory_tracker; a behavioural model pushes expected outputs per edge.
// Latency : expectations are popped and compared 1 time unit after each rising edge.
// Backpressure: n/a; stimulus is driven on the falling edge.

module tb_victory_tracker;

    logic       clk;
    logic       reset;
    logic       L, R, left_end, right_end;
    logic       game_over, match_over;
    logic [2:0] score_l, score_r;
    logic [6:0] hex_l, hex_r;

    typedef struct packed {
        logic [2:0] sl;
        logic [2:0] sr;
        logic       go;
        logic       mo;
        logic [6:0] hl;
        logic [6:0] hr;
    } obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // model state: 0 = play, 1 = round end, 2 = match over
    int         m_state = 0;
    logic [2:0] m_l = 3'd0;
    logic [2:0] m_r = 3'd0;

    victory_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .L          (L),
        .R          (R),
        .left_end   (left_end),
        .right_end  (right_end),
        .game_over  (game_over),
        .match_over (match_over),
        .score_l    (score_l),
        .score_r    (score_r),
        .hex_l      (hex_l),
        .hex_r      (hex_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] exp_hex(input logic [2:0] v);
        logic [6:0] t [8];
        t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
        t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
        return t[v];
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{sl: score_l, sr: score_r, go: game_over, mo: match_over, hl: hex_l, hr: hex_r};
        return o;
    endfunction

    // Drive one cycle of stimulus {rst,l,r,le,re}, advance the model, push expectation.
    task automatic cycle(input logic [4:0] s);
        obs_t e;
        logic lw, rw;
        @(negedge clk);
        reset = s[4]; L = s[3]; R = s[2]; left_end = s[1]; right_end = s[0];
        @(posedge clk);
        lw = s[1] & s[3] & ~s[2] & ~s[0];
        rw = s[0] & s[2] & ~s[3] & ~s[1];
        if (s[4]) begin
            m_state = 0; m_l = 3'd0; m_r = 3'd0;
        end else if (m_state == 0) begin
            if (lw) begin
                m_l = m_l + 3'd1;
                m_state = (m_l == 3'd7) ? 2 : 1;
            end else if (rw) begin
                m_r = m_r + 3'd1;
                m_state = (m_r == 3'd7) ? 2 : 1;
            end
        end else if (m_state == 1) begin
            m_state = 0;
        end
        e = '{sl: m_l, sr: m_r, go: (m_state != 0), mo: (m_state == 2),
              hl: exp_hex(m_l), hr: exp_hex(m_r)};
        sb.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] st [3];
        obs_t o, e;
        st[0] = 5'b11111; st[1] = 5'b10000; st[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            cycle(st[i]);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL reset[%0d]: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL reset[%0d]: got %h want %h", i, o, e); end
            end
        end
    endtask

    task automatic test_basic_win();
        logic [4:0] st [3];
        obs_t o, e;
        st[0] = 5'b10000; st[1] = 5'b01010; st[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            cycle(st[i]);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL basic_win[%0d]: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL basic_win[%0d]: got %h want %h", i, o, e); end
            end
            if (i == 1) begin
                total++;
                if (hex_l !== 7'b1111001 || score_l !== 3'd1 || game_over !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_win_hex: hex_l=%b score_l=%0d go=%b want 1111001/1/1", hex_l, score_l, game_over);
                end
            end
        end
    endtask

    // Generic no-win scenarios: each table row must leave the scores untouched.
    task automatic test_no_win(input string name, input logic [4:0] press);
        logic [4:0] st [3];
        obs_t o, e;
        st[0] = 5'b10000; st[1] = press; st[2] = {1'b0, press[3:0]};
        for (int i = 0; i < 3; i++) begin
            cycle(st[i]);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL %s[%0d]: scoreboard empty", name, i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL %s[%0d]: got %h want %h", name, i, o, e); end
            end
        end
        total++;
        if (score_l !== 3'd0 || score_r !== 3'd0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL %s_final: sl=%0d sr=%0d go=%b want 0/0/0", name, score_l, score_r, game_over);
        end
    endtask

    task automatic test_round_end_ignore();
        logic [4:0] st [4];
        obs_t o, e;
        st[0] = 5'b10000; st[1] = 5'b01010; st[2] = 5'b01010; st[3] = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            cycle(st[i]);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL round_end[%0d]: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL round_end[%0d]: got %h want %h", i, o, e); end
            end
        end
        total++;
        if (score_l !== 3'd1) begin
            bad++; $display("FAIL round_end_once: score_l=%0d want 1", score_l);
        end
    endtask

    task automatic test_match_end();
        logic [4:0] st [25];
        obs_t o, e;
        st[0] = 5'b10000;
        for (int k = 0; k < 7; k++) begin st[1 + 2*k] = 5'b00101; st[2 + 2*k] = 5'b00000; end
        for (int k = 0; k < 10; k++) st[15 + k] = (k % 2 == 0) ? 5'b01010 : 5'b00101;
        for (int i = 0; i < 25; i++) begin
            cycle(st[i]);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL match_end[%0d]: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL match_end[%0d]: got %h want %h", i, o, e); end
            end
        end
        total++;
        if (score_r !== 3'd7 || score_l !== 3'd0 || hex_r !== 7'b1111000 ||
            match_over !== 1'b1 || game_over !== 1'b1) begin
            bad++;
            $display("FAIL match_end_final: sr=%0d sl=%0d hex_r=%b mo=%b go=%b want 7/0/1111000/1/1",
                     score_r, score_l, hex_r, match_over, game_over);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] st [20];
        obs_t o, e;
        st[0] = 5'b10000; st[1] = 5'b01010; st[2] = 5'b00000; st[3] = 5'b11010;
        for (int k = 0; k < 7; k++) begin st[4 + 2*k] = 5'b01010; st[5 + 2*k] = 5'b00000; end
        st[18] = 5'b10000; st[19] = 5'b01010;
        for (int i = 0; i < 20; i++) begin
            cycle(st[i]);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL reset_mid[%0d]: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL reset_mid[%0d]: got %h want %h", i, o, e); end
            end
            if (i == 3 || i == 18) begin
                total++;
                if (score_l !== 3'd0 || score_r !== 3'd0 || game_over !== 1'b0 || match_over !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_zero[%0d]: sl=%0d sr=%0d go=%b mo=%b want 0/0/0/0",
                             i, score_l, score_r, game_over, match_over);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] s;
        obs_t o, e;
        for (int i = 0; i < 400; i++) begin
            s = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) s[4] = 1'b1;
            cycle(s);
            o = sample(); total++;
            if (sb.size() == 0) begin bad++; $display("FAIL random[%0d]: scoreboard empty", i); end
            else begin
                e = sb.pop_front();
                if (o !== e) begin bad++; $display("FAIL random[%0d]: stim=%b got %h want %h", i, s, o, e); end
            end
        end
    endtask

    initial begin
        reset = 1'b0; L = 1'b0; R = 1'b0; left_end = 1'b0; right_end = 1'b0;
        test_reset();
        test_basic_win();
        test_no_win("simultaneous", 5'b01110);
        test_no_win("illegal_ends", 5'b01011);
        test_no_win("no_end_lit",   5'b01000);
        test_no_win("right_no_end", 5'b00100);
        test_round_end_ignore();
        test_match_end();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/victory_tracker.md
VICTORY_TRACKER -- requirements
Module: victory_tracker

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning (clock and reset first).
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- L  input  1  left-player press, conditioned one-cycle pulse.
- R  input  1  right-player press, conditioned one-cycle pulse.
- left_end  input  1  leftmost playfield light is on.
- right_end  input  1  rightmost playfield light is on.
- game_over  output  1  round finished; drives playfield light re-centering.
- match_over  output  1  one player has reached 7 points.
- score_l  output  3  left-player score, 0..7.
- score_r  output  3  right-player score, 0..7.
- hex_l  output  7  active-low 7-segment code for score_l, bit order {g,f,e,d,c,b,a}.
- hex_r  output  7  active-low 7-segment code for score_r, same bit order.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 The block SHALL implement a registered FSM with three states: PLAY, ROUND_END and MATCH_OVER.
REQ-004 In PLAY, a left win SHALL be the condition left_end & L & ~R & ~right_end, sampled on a clock edge.
REQ-005 In PLAY, a right win SHALL be the condition right_end & R & ~L & ~left_end, sampled on a clock edge.
REQ-006 When L and R are both high, or left_end and right_end are both high, the block SHALL declare no win and SHALL stay in PLAY.
REQ-007 On a win edge, the winner's score SHALL increment by 1 and the next state SHALL be ROUND_END, or MATCH_OVER if the new score equals 7.
REQ-008 game_over SHALL be a registered, state-decoded output: high in ROUND_END and MATCH_OVER, low in PLAY.
REQ-009 game_over SHALL therefore rise on the edge that registers the win, with 1 cycle of latency from the sampled win condition.
REQ-010 ROUND_END SHALL last exactly 1 cycle, then return to PLAY unconditionally; all inputs SHALL be ignored in ROUND_END.
REQ-011 MATCH_OVER SHALL be absorbing until reset: game_over and match_over held at 1, scores frozen, all inputs ignored.
REQ-012 match_over SHALL be 1 only in MATCH_OVER.
REQ-013 Scores SHALL never wrap; 7 is reachable only on entry to MATCH_OVER, and no increment SHALL occur afterwards.
REQ-014 Only the winner's score SHALL change on a win; the loser's score SHALL be unchanged.
REQ-015 hex_l and hex_r SHALL be combinational decodes of the score registers, active-low, as follows:
- 0=1000000
- 1=1111001
- 2=0100100
- 3=0110000
- 4=0011001
- 5=0010010
- 6=0000010
- 7=1111000

Reset
REQ-016 Reset SHALL be synchronous and active-high, with priority over every other transition, in any state.
REQ-017 After a reset edge, the outputs SHALL be:
- state = PLAY
- score_l = 0, score_r = 0
- game_over = 0, match_over = 0
- hex_l = hex_r = 1000000
REQ-018 A reset asserted in the same cycle as a win condition SHALL win, i.e. the reset values apply and no score is incremented.
REQ-019 A reset asserted during ROUND_END or MATCH_OVER SHALL return the block to PLAY with zero scores on the next edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic left win: reset; left_end=1, L pulse -> next edge score_l=1, hex_l=1111001, game_over=1 for exactly 1 cycle, then PLAY.
- Simultaneous press: left_end=1, L=R=1 for 1 cycle -> scores unchanged, game_over stays 0.
- Illegal ends: left_end=right_end=1, L pulse -> no score change.
- Press with no end lit: left_end=right_end=0, L pulse -> no score change, game_over stays 0.
- Match end: 7 right wins -> score_r=7, hex_r=1111000, match_over=1 and game_over=1 held; further L/R wins ignored for 10 cycles.
- Input ignored in ROUND_END: win, then a second winning press during the ROUND_END cycle -> score increments once only.
- Reset mid-operation: reset in the same cycle as a winning press, and reset during MATCH_OVER -> scores 0, game_over=0, match_over=0 next edge.
